// File: rtl/sync_fifo_ctrl_if.sv
// Bus bundle for sync_fifo_ctrl: flush, write/read requests, read data,
// occupancy, status flags, threshold inputs and error reporting.
// The master side belongs to the producer/consumer and the slave side to the FIFO.
interface sync_fifo_ctrl_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int PTR_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH = 16
);
  // Control and requests
  logic                     flush;
  logic                     w_en;
  logic [DATA_WIDTH-1:0]    data_in;
  logic                     r_en;

  // Read return
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;

  // Occupancy thresholds and status
  logic [PTR_WIDTH:0]       af_thresh;
  logic [PTR_WIDTH:0]       ae_thresh;
  logic [PTR_WIDTH:0]       count;
  logic                     full;
  logic                     empty;
  logic                     half_full;
  logic                     almost_full;
  logic                     almost_empty;

  // Error reporting
  logic                     write_error;
  logic                     read_error;
  logic [ERR_CNT_WIDTH-1:0] overflow_cnt;
  logic [ERR_CNT_WIDTH-1:0] underflow_cnt;

  modport master (
    output flush, w_en, data_in, r_en, af_thresh, ae_thresh,
    input  data_out, data_valid, count, full, empty, half_full,
           almost_full, almost_empty, write_error, read_error,
           overflow_cnt, underflow_cnt
  );

  modport slave (
    input  flush, w_en, data_in, r_en, af_thresh, ae_thresh,
    output data_out, data_valid, count, full, empty, half_full,
           almost_full, almost_empty, write_error, read_error,
           overflow_cnt, underflow_cnt
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with an inferred storage array and a registered
// read port.
// Tracks occupancy with registered full/empty/half-full flags. The almost-full
// and almost-empty flags compare the count against live threshold inputs.
// Rejected requests give one-cycle error pulses and bump saturating counters.
// A synchronous flush empties the FIFO but keeps data_out and the error counters.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 256,
  parameter int PTR_WIDTH     = $clog2(DEPTH),
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_ctrl_if.slave     bus
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] HALF_CNT = (PTR_WIDTH+1)'(DEPTH / 2);
  localparam logic [PTR_WIDTH:0] CNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  // Storage array; never reset, so it can map onto block RAM
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State registers
  logic [PTR_WIDTH-1:0]     wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0]     rptr_q, rptr_d;
  logic [PTR_WIDTH:0]       count_q, count_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     half_full_q, half_full_d;
  logic [DATA_WIDTH-1:0]    data_out_q;
  logic                     data_valid_q, data_valid_d;
  logic                     write_error_q, write_error_d;
  logic                     read_error_q, read_error_d;
  logic [ERR_CNT_WIDTH-1:0] overflow_cnt_q, overflow_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] underflow_cnt_q, underflow_cnt_d;

  // Acceptance is decided from registered state only, so full and empty
  // never depend combinationally on the requests.
  logic wr_accept;
  logic rd_accept;
  logic wr_reject;
  logic rd_reject;
  logic wr_fire;
  logic rd_fire;

  assign wr_accept = bus.w_en & ~full_q;
  assign rd_accept = bus.r_en & ~empty_q;
  assign wr_reject = bus.w_en & full_q;
  assign rd_reject = bus.r_en & empty_q;

  // A flush cycle swallows both requests; reset likewise blocks the array write
  assign wr_fire = wr_accept & ~bus.flush & ~rst;
  assign rd_fire = rd_accept & ~bus.flush;

  // Next-state computation for pointers, occupancy, flags and error reporting
  always_comb begin
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    count_d         = count_q;
    data_valid_d    = 1'b0;
    write_error_d   = 1'b0;
    read_error_d    = 1'b0;
    overflow_cnt_d  = overflow_cnt_q;
    underflow_cnt_d = underflow_cnt_q;

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_accept) begin
        wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_accept) begin
        rptr_d       = rptr_q + PTR_ONE;
        data_valid_d = 1'b1;
      end
      if (wr_accept && !rd_accept) begin
        count_d = count_q + CNT_ONE;
      end else if (rd_accept && !wr_accept) begin
        count_d = count_q - CNT_ONE;
      end

      write_error_d = wr_reject;
      read_error_d  = rd_reject;
      if (wr_reject && (overflow_cnt_q != '1)) begin
        overflow_cnt_d = overflow_cnt_q + ERR_ONE;
      end
      if (rd_reject && (underflow_cnt_q != '1)) begin
        underflow_cnt_d = underflow_cnt_q + ERR_ONE;
      end
    end

    // These flags are registered from the next count, so they line up with count
    full_d      = (count_d == FULL_CNT);
    empty_d     = (count_d == '0);
    half_full_d = (count_d >= HALF_CNT);
  end

  // Control and status registers, with reset taking priority over flush and requests
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
      empty_q         <= 1'b1;
      half_full_q     <= 1'b0;
      data_valid_q    <= 1'b0;
      write_error_q   <= 1'b0;
      read_error_q    <= 1'b0;
      overflow_cnt_q  <= '0;
      underflow_cnt_q <= '0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      full_q          <= full_d;
      empty_q         <= empty_d;
      half_full_q     <= half_full_d;
      data_valid_q    <= data_valid_d;
      write_error_q   <= write_error_d;
      read_error_q    <= read_error_d;
      overflow_cnt_q  <= overflow_cnt_d;
      underflow_cnt_q <= underflow_cnt_d;
    end
  end

  // Array write port
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wptr_q] <= data_in_word();
    end
  end

  // Registered read port; holds its word until the next accepted read
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (rd_fire) begin
      data_out_q <= mem[rptr_q];
    end
  end

  // Write data taken straight from the bus
  function automatic logic [DATA_WIDTH-1:0] data_in_word();
    return bus.data_in;
  endfunction

  // Outputs
  assign bus.data_out      = data_out_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.count         = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.half_full     = half_full_q;
  assign bus.write_error   = write_error_q;
  assign bus.read_error    = read_error_q;
  assign bus.overflow_cnt  = overflow_cnt_q;
  assign bus.underflow_cnt = underflow_cnt_q;

  // The almost flags use the live thresholds, so a threshold change shows up
  // in the same cycle.
  assign bus.almost_full   = (count_q >= bus.af_thresh);
  assign bus.almost_empty  = (count_q <= bus.ae_thresh);

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed testbench for sync_fifo_ctrl with DEPTH=8.
// Covers reset, the fill/drain order, full and empty collisions, the almost
// thresholds, flush, pointer wrap-around and a reset during a burst.
module tb_sync_fifo_ctrl;
  localparam int DW  = 8;
  localparam int DEP = 8;
  localparam int PW  = 3;
  localparam int EW  = 16;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .PTR_WIDTH(PW), .ERR_CNT_WIDTH(EW)) bus ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .DEPTH(DEP), .PTR_WIDTH(PW), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush   = 1'b0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
  endtask

  initial begin
    logic [7:0] v;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    bus.af_thresh = 4'd6;
    bus.ae_thresh = 4'd2;

    // Reset and idle
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("rst_count", 32'(bus.count), 32'd0);
    check_eq("rst_empty", 32'(bus.empty), 32'd1);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_half", 32'(bus.half_full), 32'd0);
    check_eq("rst_aempty", 32'(bus.almost_empty), 32'd1);
    check_eq("rst_afull", 32'(bus.almost_full), 32'd0);
    check_eq("rst_dvalid", 32'(bus.data_valid), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow_cnt), 32'd0);
    check_eq("rst_unf", 32'(bus.underflow_cnt), 32'd0);

    // Fill with 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      bus.w_en    = 1'b1;
      bus.data_in = 8'(i * 8'h11);
      step();
      check_eq($sformatf("fill%0d_count", i), 32'(bus.count), 32'(i));
      check_eq($sformatf("fill%0d_half", i), 32'(bus.half_full), 32'(i >= 4));
      check_eq($sformatf("fill%0d_full", i), 32'(bus.full), 32'(i == 8));
      check_eq($sformatf("fill%0d_afull", i), 32'(bus.almost_full), 32'(i >= 6));
      check_eq($sformatf("fill%0d_aempty", i), 32'(bus.almost_empty), 32'(i <= 2));
    end
    bus.w_en = 1'b0;

    // Full with both requests: the read wins and the write is rejected
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'hEE;
    step();
    idle_inputs();
    check_eq("ovf_werr", 32'(bus.write_error), 32'd1);
    check_eq("ovf_cnt", 32'(bus.overflow_cnt), 32'd1);
    check_eq("ovf_count", 32'(bus.count), 32'd7);
    check_eq("ovf_dout", 32'(bus.data_out), 32'h11);
    check_eq("ovf_dvalid", 32'(bus.data_valid), 32'd1);
    check_eq("ovf_full", 32'(bus.full), 32'd0);

    // Drain the rest; the rejected 0xEE must never appear
    for (int i = 2; i <= 8; i++) begin
      bus.r_en = 1'b1;
      step();
      check_eq($sformatf("drain%0d_dout", i), 32'(bus.data_out), 32'(8'(i * 8'h11)));
      check_eq($sformatf("drain%0d_dvalid", i), 32'(bus.data_valid), 32'd1);
      check_eq($sformatf("drain%0d_werr", i), 32'(bus.write_error), 32'd0);
    end
    bus.r_en = 1'b0;
    check_eq("drain_empty", 32'(bus.empty), 32'd1);
    check_eq("drain_count", 32'(bus.count), 32'd0);
    step();
    check_eq("drain_dvalid_off", 32'(bus.data_valid), 32'd0);
    check_eq("drain_dout_hold", 32'(bus.data_out), 32'h88);

    // Underflow: two read-only cycles, then a combined cycle while empty
    for (int i = 1; i <= 2; i++) begin
      bus.r_en = 1'b1;
      step();
      check_eq($sformatf("unf%0d_rerr", i), 32'(bus.read_error), 32'd1);
      check_eq($sformatf("unf%0d_dvalid", i), 32'(bus.data_valid), 32'd0);
    end
    bus.w_en    = 1'b1;
    bus.data_in = 8'h5A;
    step();
    idle_inputs();
    check_eq("unf3_rerr", 32'(bus.read_error), 32'd1);
    check_eq("unf3_dvalid", 32'(bus.data_valid), 32'd0);
    check_eq("unf_cnt", 32'(bus.underflow_cnt), 32'd3);
    check_eq("unf_count", 32'(bus.count), 32'd1);
    step();
    check_eq("unf_rerr_off", 32'(bus.read_error), 32'd0);
    bus.r_en = 1'b1;
    step();
    bus.r_en = 1'b0;
    check_eq("unf_read_dout", 32'(bus.data_out), 32'h5A);
    check_eq("unf_read_dvalid", 32'(bus.data_valid), 32'd1);

    // Almost flags with a threshold change in the middle
    for (int i = 0; i < 4; i++) begin
      bus.w_en    = 1'b1;
      bus.data_in = 8'(8'hA0 + i);
      step();
    end
    bus.w_en = 1'b0;
    check_eq("thr_count4", 32'(bus.count), 32'd4);
    check_eq("thr_afull6", 32'(bus.almost_full), 32'd0);
    check_eq("thr_aempty", 32'(bus.almost_empty), 32'd0);
    bus.af_thresh = 4'd3;
    #1;
    check_eq("thr_afull3", 32'(bus.almost_full), 32'd1);
    bus.af_thresh = 4'd6;
    bus.ae_thresh = 4'd4;
    #1;
    check_eq("thr_afull_back", 32'(bus.almost_full), 32'd0);
    check_eq("thr_aempty4", 32'(bus.almost_empty), 32'd1);
    bus.ae_thresh = 4'd2;

    // Fifth word, then flush with both requests high
    bus.w_en    = 1'b1;
    bus.data_in = 8'hA4;
    step();
    check_eq("pre_flush_count", 32'(bus.count), 32'd5);
    bus.flush   = 1'b1;
    bus.w_en    = 1'b1;
    bus.r_en    = 1'b1;
    bus.data_in = 8'hFF;
    step();
    idle_inputs();
    check_eq("flush_count", 32'(bus.count), 32'd0);
    check_eq("flush_empty", 32'(bus.empty), 32'd1);
    check_eq("flush_werr", 32'(bus.write_error), 32'd0);
    check_eq("flush_rerr", 32'(bus.read_error), 32'd0);
    check_eq("flush_dvalid", 32'(bus.data_valid), 32'd0);
    check_eq("flush_dout", 32'(bus.data_out), 32'h5A);
    check_eq("flush_ovf", 32'(bus.overflow_cnt), 32'd1);
    check_eq("flush_unf", 32'(bus.underflow_cnt), 32'd3);

    // Streaming through the pointer wrap: write 0xC0..0xCB, reading one behind
    for (int k = 0; k <= 12; k++) begin
      bus.w_en    = (k < 12);
      bus.data_in = 8'(8'hC0 + k);
      bus.r_en    = (k >= 1);
      step();
      if (k >= 1) begin
        v = 8'(8'hC0 + k - 1);
        check_eq($sformatf("wrap%0d_dout", k), 32'(bus.data_out), 32'(v));
        check_eq($sformatf("wrap%0d_dvalid", k), 32'(bus.data_valid), 32'd1);
      end
      check_eq($sformatf("wrap%0d_count", k), 32'(bus.count), 32'(k < 12 ? 1 : 0));
    end
    idle_inputs();

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      bus.w_en    = 1'b1;
      bus.data_in = 8'(8'hD0 + i);
      step();
    end
    bus.r_en = 1'b1;
    step();
    rst      = 1'b1;
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    step();
    check_eq("mrst_count", 32'(bus.count), 32'd0);
    check_eq("mrst_empty", 32'(bus.empty), 32'd1);
    check_eq("mrst_full", 32'(bus.full), 32'd0);
    check_eq("mrst_half", 32'(bus.half_full), 32'd0);
    check_eq("mrst_dout", 32'(bus.data_out), 32'd0);
    check_eq("mrst_dvalid", 32'(bus.data_valid), 32'd0);
    check_eq("mrst_werr", 32'(bus.write_error), 32'd0);
    check_eq("mrst_rerr", 32'(bus.read_error), 32'd0);
    check_eq("mrst_ovf", 32'(bus.overflow_cnt), 32'd0);
    check_eq("mrst_unf", 32'(bus.underflow_cnt), 32'd0);
    rst = 1'b0;
    idle_inputs();
    step();
    check_eq("post_rst_count", 32'(bus.count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
